// File: rtl/jk_pkg.sv
// Shared types for the JK drive sequencer: FSM states and {J,K} excitation codes.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] TOG  = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation: the {J,K} needed to move a JK flop from cur to tgt.
module jk_excite
  import jk_pkg::*;
(
  input  logic cur,
  input  logic tgt,
  input  logic use_toggle,
  output logic j,
  output logic k
);

  logic [1:0] jk;

  always_comb begin
    jk = HOLD;
    if (cur != tgt) begin
      if (use_toggle) jk = TOG;
      else            jk = tgt ? SET : RST;
    end
  end

  assign {j, k} = jk;

endmodule

// File: rtl/jk_drive_seq.sv
// Drives a downstream JK flop to a requested Q value, then checks the fed-back Q.
//
//   state | meaning
//   IDLE  | ready for a target; mismatch pulse of the previous check shows here
//   DRIVE | J/K excitation applied for exactly one cycle
//   CHECK | J/K released; q_fb compared with tgt_r on the edge leaving this state
module jk_drive_seq
  import jk_pkg::*;
#(
  parameter int ERR_W      = 8,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             q_fb,
  input  logic             clr_err,
  output logic             J,
  output logic             K,
  output logic             busy,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t state, state_next;
  logic   tgt_r, cur_r;
  logic   tgt_d, cur_d;
  logic   accept;
  logic   exc_j, exc_k;
  logic   check_fail;

  assign tgt_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = tgt_valid & tgt_ready;
  assign check_fail = (state == CHECK) && (q_fb != tgt_r);

  // Excitation is evaluated on the D side of tgt_r/cur_r so J/K can be
  // registered on the accept edge and appear in the DRIVE cycle.
  assign tgt_d = accept ? tgt_bit : tgt_r;
  assign cur_d = accept ? q_fb    : cur_r;

  jk_excite u_excite (
    .cur        (cur_d),
    .tgt        (tgt_d),
    .use_toggle (USE_TOGGLE),
    .j          (exc_j),
    .k          (exc_k)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DRIVE;
      DRIVE:   state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tgt_r    <= 1'b0;
      cur_r    <= 1'b0;
      J        <= 1'b0;
      K        <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_next;
      tgt_r    <= tgt_d;
      cur_r    <= cur_d;
      J        <= accept & exc_j;
      K        <= accept & exc_k;
      mismatch <= check_fail;
      // Clear takes priority over a coincident mismatch; the pulse still fires.
      if (clr_err)
        err_cnt <= '0;
      else if (check_fail && err_cnt != ERR_MAX)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_jk_drive_seq.sv
// Directed bench for jk_drive_seq: set/reset and toggle variants with a JK flop model,
// plus a stuck-feedback instance with a 2-bit error counter.
module tb_jk_drive_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tgt_valid = 1'b0;
  logic tgt_bit = 1'b0;
  logic clr_err = 1'b0;

  logic       ready0, ready1, ready2;
  logic       j0, k0, j1, k1, j2, k2;
  logic       busy0, busy1, busy2;
  logic       mis0, mis1, mis2;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic       q0, q1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  jk_drive_seq #(.ERR_W(8), .USE_TOGGLE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(ready0), .q_fb(q0), .clr_err(clr_err), .J(j0), .K(k0),
    .busy(busy0), .mismatch(mis0), .err_cnt(err0));

  jk_drive_seq #(.ERR_W(8), .USE_TOGGLE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(ready1), .q_fb(q1), .clr_err(clr_err), .J(j1), .K(k1),
    .busy(busy1), .mismatch(mis1), .err_cnt(err1));

  jk_drive_seq #(.ERR_W(2), .USE_TOGGLE(1'b0)) dut2 (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(ready2), .q_fb(1'b0), .clr_err(clr_err), .J(j2), .K(k2),
    .busy(busy2), .mismatch(mis2), .err_cnt(err2));

  // Behavioural downstream JK flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0 <= 1'b0;
      q1 <= 1'b0;
    end else begin
      case ({j0, k0})
        2'b10:   q0 <= 1'b1;
        2'b01:   q0 <= 1'b0;
        2'b11:   q0 <= ~q0;
        default: q0 <= q0;
      endcase
      case ({j1, k1})
        2'b10:   q1 <= 1'b1;
        2'b01:   q1 <= 1'b0;
        2'b11:   q1 <= ~q1;
        default: q1 <= q1;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // One full transfer on dut0/dut1, starting in IDLE
  task automatic send(input logic b, input logic [1:0] jk0_exp, input logic [1:0] jk1_exp,
                      input logic q_exp);
    tgt_valid = 1'b1;
    tgt_bit   = b;
    chk("ready_idle", ready0, 1'b1);
    step();
    tgt_valid = 1'b0;
    chk("jk_set_reset", {j0, k0}, jk0_exp);
    chk("jk_toggle", {j1, k1}, jk1_exp);
    chk("busy_drive", busy0, 1'b1);
    chk("ready_drive", ready0, 1'b0);
    step();
    chk("jk_check0", {j0, k0}, 2'b00);
    chk("jk_check1", {j1, k1}, 2'b00);
    chk("q_set_reset", q0, q_exp);
    chk("q_toggle", q1, q_exp);
    step();
    chk("mismatch0", mis0, 1'b0);
    chk("mismatch1", mis1, 1'b0);
    chk("busy_idle", busy0, 1'b0);
  endtask

  initial begin
    int acc;
    int jcnt;

    // Reset held with a target offered
    reset = 1'b0;
    tgt_valid = 1'b1;
    tgt_bit = 1'b1;
    repeat (3) step();
    chk("rst_jk", {j0, k0}, 2'b00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_mismatch", mis0, 1'b0);
    chk("rst_err", err0, 8'd0);
    tgt_valid = 1'b0;
    reset = 1'b1;
    chk("rst_ready", ready0, 1'b1);
    step();
    chk("rst_no_accept", busy0, 1'b0);

    // Set/reset and toggle excitation, back-to-back accepts 3 cycles apart
    pulse_reset();
    send(1'b1, 2'b10, 2'b11, 1'b1);
    send(1'b0, 2'b01, 2'b11, 1'b0);
    send(1'b0, 2'b00, 2'b00, 1'b0);
    send(1'b1, 2'b10, 2'b11, 1'b1);

    // Stuck feedback on dut2: saturating 2-bit error count
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      tgt_valid = 1'b1;
      tgt_bit = 1'b1;
      step();
      tgt_valid = 1'b0;
      chk("mis_low_drive", mis2, 1'b0);
      step();
      step();
      chk("mis_pulse", mis2, 1'b1);
      chk("err_sat", err2, (i < 3) ? i + 1 : 3);
    end

    // Clear coincident with a mismatch: clear wins, pulse still emitted
    tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_mis_pulse", mis2, 1'b1);
    chk("clr_err_zero", err2, 2'd0);

    // Valid held high: one accept per 3 cycles
    acc = 0;
    jcnt = 0;
    tgt_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (tgt_valid && ready0) acc++;
      step();
      if (j2) jcnt++;
    end
    tgt_valid = 1'b0;
    chk("accept_count", acc, 3);
    chk("drive_pulses", jcnt, 3);
    chk("err_after_burst", err2, 2'd3);

    // Reset during DRIVE abandons the transfer
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("err_cleared", err2, 2'd0);
    tgt_valid = 1'b1;
    tgt_bit = 1'b1;
    step();
    tgt_valid = 1'b0;
    chk("abort_drive_jk", {j2, k2}, 2'b10);
    #1 reset = 1'b0;
    #1;
    chk("abort_jk_zero", {j2, k2}, 2'b00);
    chk("abort_busy", busy2, 1'b0);
    #2 reset = 1'b1;
    step();
    chk("abort_no_mis_a", mis2, 1'b0);
    step();
    step();
    chk("abort_no_mis_b", mis2, 1'b0);
    chk("abort_err", err2, 2'd0);
    chk("abort_idle", busy2, 1'b0);
    chk("abort_ready", ready2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
